cflog_repeat_compactor: RTL and testbench

Hardware compaction stage that sits beside the control-flow log memory and shrinks runs of identical consecutive (src, dest) entries. After each hardware log write it reads back the newest entries through the log memory's block-detect read ports, then does one of two things. It either overwrites the newest slot with a repeat marker, or it increments an existing marker and asks the logger to roll its pointer back one entry. Its write requests use the log memory's Spec-CFA write path: detect_active, active_block_cflog_addr, spec_upper and spec_lower.

---
 rtl/cflog_compact_pkg.sv | 32 +++
 rtl/cflog_repeat_decide.sv | 60 ++++++
 rtl/cflog_repeat_compactor.sv | 152 +++++++++++++++
 tb/tb_cflog_repeat_compactor.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cflog_compact_pkg.sv
// Shared types and defaults for the control-flow log repeat compactor.
//
// Contents:
//   state_t  - compactor FSM states (IDLE, RD_N, RD_P2, WRITE)
//   action_t - write action chosen by the decision logic
//              (NONE, MARK_NEW, MARK_INC)
//   entry_t  - one log entry: a {src, dest} word pair
//   REPEAT_TAG_DEF / MAX_REPEAT_DEF - default marker tag and saturation count
package cflog_compact_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_N  = 2'd1,
    RD_P2 = 2'd2,
    WRITE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    MARK_NEW = 2'd1,
    MARK_INC = 2'd2
  } action_t;

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dest;
  } entry_t;

  localparam logic [15:0] REPEAT_TAG_DEF = 16'hFFFF;
  localparam logic [15:0] MAX_REPEAT_DEF = 16'hFFFE;

endpackage

// File: rtl/cflog_repeat_decide.sv
// Combinational next-state / action decision for the repeat compactor.
//
// Ports:
//   state      in   current FSM state
//   start      in   logger write strobe (only meaningful in IDLE)
//   ptr        in   pointer under consideration (live in IDLE, latched otherwise)
//   n, p1, p2  in   newest, previous and pre-previous entries
//   next_state out  next FSM state
//   action     out  write action to perform in WRITE
//   spec_lower out  word to write at target+1 (marker repeat count)
module cflog_repeat_decide
  import cflog_compact_pkg::*;
#(
  parameter logic [15:0] REPEAT_TAG = REPEAT_TAG_DEF,
  parameter logic [15:0] MAX_REPEAT = MAX_REPEAT_DEF
) (
  input  state_t      state,
  input  logic        start,
  input  logic [15:0] ptr,
  input  entry_t      n,
  input  entry_t      p1,
  input  entry_t      p2,
  output state_t      next_state,
  output action_t     action,
  output logic [15:0] spec_lower
);

  always_comb begin
    next_state = IDLE;
    action     = NONE;
    spec_lower = 16'h0000;
    case (state)
      IDLE: begin
        // Fewer than two entries in the log: nothing to compare against.
        if (start && (ptr >= 16'd4)) next_state = RD_N;
      end
      RD_N: begin
        if ((p1.src == REPEAT_TAG) && (ptr >= 16'd6)) begin
          next_state = RD_P2;
        end else if ((p1.src != REPEAT_TAG) && (n == p1)) begin
          // Second occurrence: newest slot becomes a marker with count 1.
          next_state = WRITE;
          action     = MARK_NEW;
          spec_lower = 16'd1;
        end
      end
      RD_P2: begin
        // A saturated marker or a different edge leaves N as a fresh entry.
        if ((n == p2) && (p1.dest < MAX_REPEAT)) begin
          next_state = WRITE;
          action     = MARK_INC;
          spec_lower = p1.dest + 16'd1;
        end
      end
      WRITE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: rtl/cflog_repeat_compactor.sv
// Repeat compactor for the control-flow log memory. After each logger write
// it reads back the newest entries and either turns the newest slot into a
// repeat marker {REPEAT_TAG, 1}, or increments the marker just before it and
// asks the logger to roll its pointer back by one entry.
//
// Optional feature macro: CFLOG_COMPACT_STATS_EN adds the saved_entries
// counter output (number of entries removed, saturating at 16'hFFFF).
//
// Ports:
//   mclk, puc_rst_n          clock, async active-low reset
//   cflow_hw_wen             logger write strobe
//   cflow_logs_ptr_din       logger pointer at the strobe
//   cflog_bd_rd_src/dest     log words at bd_log_ptr / bd_log_ptr+1
//   prev_src/prev_dest       log words at bd_log_ptr-2 / bd_log_ptr-1
//   bd_log_ptr               registered read index into the log memory
//   detect_active            one-cycle write strobe to the log memory
//   active_block_cflog_addr  write target plus 2
//   spec_upper/spec_lower    words written at target / target+1
//   ptr_rollback             one-cycle pulse: logger subtracts 2 from pointer
//   comp_busy                high whenever the FSM is not IDLE
//   comp_ovf                 sticky: strobe arrived while busy
//   saved_entries            (stats build only) case-B write count
//
// Handshake: the logger may strobe cflow_hw_wen only while comp_busy is low;
// a strobe while busy is dropped and recorded in comp_ovf.
module cflog_repeat_compactor
  import cflog_compact_pkg::*;
#(
  parameter logic [15:0] REPEAT_TAG = REPEAT_TAG_DEF,
  parameter logic [15:0] MAX_REPEAT = MAX_REPEAT_DEF
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic        cflow_hw_wen,
  input  logic [15:0] cflow_logs_ptr_din,
  input  logic [15:0] cflog_bd_rd_src,
  input  logic [15:0] cflog_bd_rd_dest,
  input  logic [15:0] prev_src,
  input  logic [15:0] prev_dest,
  output logic [15:0] bd_log_ptr,
  output logic        detect_active,
  output logic [15:0] active_block_cflog_addr,
  output logic [15:0] spec_upper,
  output logic [15:0] spec_lower,
  output logic        ptr_rollback,
  output logic        comp_busy,
  output logic        comp_ovf
`ifdef CFLOG_COMPACT_STATS_EN
  ,
  output logic [15:0] saved_entries
`endif
);

  state_t      state_q, next_state;
  action_t     action;
  logic [15:0] ptr_q;
  entry_t      n_q, p1_q, p2_q;
  entry_t      live_n, live_prev;
  entry_t      dec_n, dec_p1, dec_p2;
  logic [15:0] dec_ptr;
  logic [15:0] dec_lower;

  assign live_n    = '{src: cflog_bd_rd_src, dest: cflog_bd_rd_dest};
  assign live_prev = '{src: prev_src, dest: prev_dest};

  // The read ports are combinational, so each read state decides on the live
  // port values; earlier reads come from the latches.
  always_comb begin
    dec_ptr = (state_q == IDLE)  ? cflow_logs_ptr_din : ptr_q;
    dec_n   = (state_q == RD_N)  ? live_n    : n_q;
    dec_p1  = (state_q == RD_N)  ? live_prev : p1_q;
    dec_p2  = (state_q == RD_P2) ? live_prev : p2_q;
  end

  cflog_repeat_decide #(
    .REPEAT_TAG (REPEAT_TAG),
    .MAX_REPEAT (MAX_REPEAT)
  ) u_decide (
    .state      (state_q),
    .start      (cflow_hw_wen),
    .ptr        (dec_ptr),
    .n          (dec_n),
    .p1         (dec_p1),
    .p2         (dec_p2),
    .next_state (next_state),
    .action     (action),
    .spec_lower (dec_lower)
  );

  assign comp_busy = (state_q != IDLE);

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q                 <= IDLE;
      ptr_q                   <= 16'h0000;
      n_q                     <= '0;
      p1_q                    <= '0;
      p2_q                    <= '0;
      bd_log_ptr              <= 16'h0000;
      detect_active           <= 1'b0;
      active_block_cflog_addr <= 16'h0000;
      spec_upper              <= 16'h0000;
      spec_lower              <= 16'h0000;
      ptr_rollback            <= 1'b0;
      comp_ovf                <= 1'b0;
    end else begin
      state_q       <= next_state;
      detect_active <= 1'b0;
      ptr_rollback  <= 1'b0;

      if (cflow_hw_wen && (state_q != IDLE)) comp_ovf <= 1'b1;

      case (state_q)
        IDLE: begin
          if (next_state == RD_N) begin
            ptr_q      <= cflow_logs_ptr_din;
            bd_log_ptr <= cflow_logs_ptr_din - 16'd2;
          end
        end
        RD_N: begin
          n_q  <= live_n;
          p1_q <= live_prev;
          if (next_state == RD_P2) bd_log_ptr <= ptr_q - 16'd4;
        end
        RD_P2: p2_q <= live_prev;
        default: ;
      endcase

      // Output registers load on entry to WRITE so the strobe lines up with
      // the WRITE state and lasts exactly one cycle.
      if (next_state == WRITE) begin
        detect_active           <= 1'b1;
        spec_upper              <= REPEAT_TAG;
        spec_lower              <= dec_lower;
        active_block_cflog_addr <= (action == MARK_INC) ? (ptr_q - 16'd2) : ptr_q;
        ptr_rollback            <= (action == MARK_INC);
      end
    end
  end

`ifdef CFLOG_COMPACT_STATS_EN
  // ptr_rollback is high exactly in case-B WRITE cycles.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      saved_entries <= 16'h0000;
    end else if (ptr_rollback && (saved_entries != 16'hFFFF)) begin
      saved_entries <= saved_entries + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cflog_repeat_compactor.sv
// Directed bench for cflog_repeat_compactor with a small log-memory model.
module tb_cflog_repeat_compactor;

  logic        mclk;
  logic        puc_rst_n;
  logic        cflow_hw_wen;
  logic [15:0] cflow_logs_ptr_din;
  logic [15:0] cflog_bd_rd_src;
  logic [15:0] cflog_bd_rd_dest;
  logic [15:0] prev_src;
  logic [15:0] prev_dest;
  logic [15:0] bd_log_ptr;
  logic        detect_active;
  logic [15:0] active_block_cflog_addr;
  logic [15:0] spec_upper;
  logic [15:0] spec_lower;
  logic        ptr_rollback;
  logic        comp_busy;
  logic        comp_ovf;
`ifdef CFLOG_COMPACT_STATS_EN
  logic [15:0] saved_entries;
`endif

  cflog_repeat_compactor dut (
    .mclk                    (mclk),
    .puc_rst_n               (puc_rst_n),
    .cflow_hw_wen            (cflow_hw_wen),
    .cflow_logs_ptr_din      (cflow_logs_ptr_din),
    .cflog_bd_rd_src         (cflog_bd_rd_src),
    .cflog_bd_rd_dest        (cflog_bd_rd_dest),
    .prev_src                (prev_src),
    .prev_dest               (prev_dest),
    .bd_log_ptr              (bd_log_ptr),
    .detect_active           (detect_active),
    .active_block_cflog_addr (active_block_cflog_addr),
    .spec_upper              (spec_upper),
    .spec_lower              (spec_lower),
    .ptr_rollback            (ptr_rollback),
    .comp_busy               (comp_busy),
    .comp_ovf                (comp_ovf)
`ifdef CFLOG_COMPACT_STATS_EN
    ,
    .saved_entries           (saved_entries)
`endif
  );

  // ---------------- clock / reset ----------------
  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // ---------------- log memory model ----------------
  logic [15:0] mem [0:63];
  logic [15:0] addr_p1, addr_m2, addr_m1;
  assign addr_p1 = bd_log_ptr + 16'd1;
  assign addr_m2 = bd_log_ptr - 16'd2;
  assign addr_m1 = bd_log_ptr - 16'd1;
  assign cflog_bd_rd_src  = (bd_log_ptr < 16'd64) ? mem[bd_log_ptr[5:0]] : 16'h0000;
  assign cflog_bd_rd_dest = (addr_p1 < 16'd64)    ? mem[addr_p1[5:0]]    : 16'h0000;
  assign prev_src         = (addr_m2 < 16'd64)    ? mem[addr_m2[5:0]]    : 16'h0000;
  assign prev_dest        = (addr_m1 < 16'd64)    ? mem[addr_m1[5:0]]    : 16'h0000;

  // Pulse counters: sampled on the falling edge, one count per high cycle.
  int det_cnt;
  int rb_cnt;
  initial begin
    det_cnt = 0;
    rb_cnt  = 0;
  end
  always @(negedge mclk) begin
    if (detect_active) det_cnt <= det_cnt + 1;
    if (ptr_rollback)  rb_cnt  <= rb_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int n_checks;
  int n_pass;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
  endtask

  task automatic put(input int p, input logic [15:0] src, input logic [15:0] dest);
    mem[p]     = src;
    mem[p + 1] = dest;
  endtask

  // Returns at the falling edge inside the cycle after the strobe edge.
  task automatic strobe(input logic [15:0] p);
    @(negedge mclk);
    cflow_hw_wen       = 1'b1;
    cflow_logs_ptr_din = p;
    @(negedge mclk);
    cflow_hw_wen       = 1'b0;
  endtask

  task automatic log_entry(input logic [15:0] p, input logic [15:0] src, input logic [15:0] dest);
    put(int'(p) - 2, src, dest);
    strobe(p);
  endtask

  localparam logic [15:0] A_SRC = 16'h1000;
  localparam logic [15:0] A_DST = 16'h2000;

  // ---------------- stimulus ----------------
  initial begin
    int det0, rb0;
    n_checks           = 0;
    n_pass             = 0;
    puc_rst_n          = 1'b0;
    cflow_hw_wen       = 1'b0;
    cflow_logs_ptr_din = 16'h0000;
    clear_mem();

    repeat (3) @(negedge mclk);
    check("rst_detect", {31'd0, detect_active}, 32'd0);
    check("rst_rollback", {31'd0, ptr_rollback}, 32'd0);
    check("rst_busy", {31'd0, comp_busy}, 32'd0);
    check("rst_ovf", {31'd0, comp_ovf}, 32'd0);
    check("rst_bd_ptr", {16'd0, bd_log_ptr}, 32'd0);
    check("rst_addr", {16'd0, active_block_cflog_addr}, 32'd0);
    check("rst_upper", {16'd0, spec_upper}, 32'd0);
    check("rst_lower", {16'd0, spec_lower}, 32'd0);
    puc_rst_n = 1'b1;

    // Distinct entries: A at ptr 2 (too few entries), B at ptr 4.
    det0 = det_cnt;
    log_entry(16'd2, A_SRC, A_DST);
    check("ptr2_idle", {31'd0, comp_busy}, 32'd0);
    log_entry(16'd4, 16'h3000, 16'h4000);
    check("ab_rdn_busy", {31'd0, comp_busy}, 32'd1);
    check("ab_rdn_bdptr", {16'd0, bd_log_ptr}, 32'd2);
    @(negedge mclk);
    check("ab_back_idle", {31'd0, comp_busy}, 32'd0);
    check("ab_no_detect", {31'd0, detect_active}, 32'd0);
    repeat (2) @(negedge mclk);
    check("ab_det_cnt", det_cnt, det0);

    // Case A: A then A.
    clear_mem();
    log_entry(16'd2, A_SRC, A_DST);
    log_entry(16'd4, A_SRC, A_DST);
    check("a_rdn_detect", {31'd0, detect_active}, 32'd0);
    @(negedge mclk);
    check("a_detect", {31'd0, detect_active}, 32'd1);
    check("a_addr", {16'd0, active_block_cflog_addr}, 32'd4);
    check("a_upper", {16'd0, spec_upper}, 32'hFFFF);
    check("a_lower", {16'd0, spec_lower}, 32'd1);
    check("a_no_rollback", {31'd0, ptr_rollback}, 32'd0);
    put(2, 16'hFFFF, 16'd1);
    @(negedge mclk);
    check("a_pulse_end", {31'd0, detect_active}, 32'd0);
    check("a_idle", {31'd0, comp_busy}, 32'd0);

    // Case B: A again at ptr 6 after marker {FFFF,1}.
    log_entry(16'd6, A_SRC, A_DST);
    check("b_rdn_bdptr", {16'd0, bd_log_ptr}, 32'd4);
    @(negedge mclk);
    check("b_rdp2_bdptr", {16'd0, bd_log_ptr}, 32'd2);
    check("b_rdp2_nodet", {31'd0, detect_active}, 32'd0);
    @(negedge mclk);
    check("b_detect", {31'd0, detect_active}, 32'd1);
    check("b_rollback", {31'd0, ptr_rollback}, 32'd1);
    check("b_addr", {16'd0, active_block_cflog_addr}, 32'd4);
    check("b_lower", {16'd0, spec_lower}, 32'd2);
    put(2, 16'hFFFF, 16'd2);
    @(negedge mclk);
    check("b_pulse_end", {31'd0, ptr_rollback}, 32'd0);
`ifdef CFLOG_COMPACT_STATS_EN
    check("b_saved", {16'd0, saved_entries}, 32'd1);
`endif

    // Saturated marker: no write, A stays fresh.
    clear_mem();
    put(0, A_SRC, A_DST);
    put(2, 16'hFFFF, 16'hFFFE);
    det0 = det_cnt;
    rb0  = rb_cnt;
    log_entry(16'd6, A_SRC, A_DST);
    @(negedge mclk);
    check("sat_rdp2_busy", {31'd0, comp_busy}, 32'd1);
    @(negedge mclk);
    check("sat_no_detect", {31'd0, detect_active}, 32'd0);
    check("sat_idle", {31'd0, comp_busy}, 32'd0);
    @(negedge mclk);
    check("sat_det_cnt", det_cnt, det0);
    check("sat_rb_cnt", rb_cnt, rb0);

    // Genuine tagged edge repeated at ptr 4: never a repeat of a marker.
    clear_mem();
    put(0, 16'hFFFF, 16'h0005);
    det0 = det_cnt;
    log_entry(16'd4, 16'hFFFF, 16'h0005);
    @(negedge mclk);
    check("tag_no_detect", {31'd0, detect_active}, 32'd0);
    check("tag_idle", {31'd0, comp_busy}, 32'd0);
    @(negedge mclk);
    check("tag_det_cnt", det_cnt, det0);

    // Strobe during RD_N: overflow flagged, sequence completes.
    clear_mem();
    log_entry(16'd2, A_SRC, A_DST);
    log_entry(16'd4, A_SRC, A_DST);
    cflow_hw_wen       = 1'b1;
    cflow_logs_ptr_din = 16'd8;
    @(negedge mclk);
    cflow_hw_wen = 1'b0;
    check("ovf_set", {31'd0, comp_ovf}, 32'd1);
    check("ovf_detect", {31'd0, detect_active}, 32'd1);
    check("ovf_addr", {16'd0, active_block_cflog_addr}, 32'd4);
    check("ovf_lower", {16'd0, spec_lower}, 32'd1);
    @(negedge mclk);
    check("ovf_idle", {31'd0, comp_busy}, 32'd0);
    check("ovf_sticky", {31'd0, comp_ovf}, 32'd1);

    // Reset during RD_P2.
    clear_mem();
    put(0, A_SRC, A_DST);
    put(2, 16'hFFFF, 16'd1);
    det0 = det_cnt;
    rb0  = rb_cnt;
    log_entry(16'd6, A_SRC, A_DST);
    @(negedge mclk);
    check("rstmid_rdp2_bd", {16'd0, bd_log_ptr}, 32'd2);
    #1 puc_rst_n = 1'b0;
    #1;
    check("rstmid_busy", {31'd0, comp_busy}, 32'd0);
    check("rstmid_ovf", {31'd0, comp_ovf}, 32'd0);
    check("rstmid_detect", {31'd0, detect_active}, 32'd0);
    @(negedge mclk);
    puc_rst_n = 1'b1;
    repeat (3) @(negedge mclk);
    check("rstmid_det_cnt", det_cnt, det0);
    check("rstmid_rb_cnt", rb_cnt, rb0);

    // First strobe after reset is accepted (same memory: case B).
    strobe(16'd6);
    check("post_rst_busy", {31'd0, comp_busy}, 32'd1);
    repeat (2) @(negedge mclk);
    check("post_rst_detect", {31'd0, detect_active}, 32'd1);
    check("post_rst_rollback", {31'd0, ptr_rollback}, 32'd1);
    check("post_rst_lower", {16'd0, spec_lower}, 32'd2);
    @(negedge mclk);
`ifdef CFLOG_COMPACT_STATS_EN
    check("post_rst_saved", {16'd0, saved_entries}, 32'd1);
`endif

    // Every write pulse seen: case A, case B, overflow case A, post-reset B.
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd2);
    check("total_det", det_cnt, exp_q.pop_front());
    check("total_rb", rb_cnt, exp_q.pop_front());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
